serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/serial_adder_if.sv | 33 +++
 rtl/halfadd.sv | 12 +
 rtl/serial_fa.sv | 19 +
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding, default width and counter sizing for serial_adder
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done request and result bundle for serial_adder
// ovf is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/halfadd.sv
// rtl/halfadd.sv - single-bit half adder cell
module halfadd (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_fa.sv
// rtl/serial_fa.sv - combinational 1-bit full adder from two halfadd cells and an OR
module serial_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic s0;
  logic c0;
  logic c1;

  halfadd u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  halfadd u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign co_o = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first WIDTH-bit adder with start/busy/done handshake
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  serial_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .co_o(fa_co)
  );

  assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            c_q     <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          c_q      <= fa_co;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= sum_sh_d;
            cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q is the carry into the MSB on this last bit.
            ovf_q   <= c_q ^ fa_co;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
// Overflow vectors run only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a negedge so the following posedge accepts it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycle j is the low phase after edge E(j-1); edges returns the edge that raised done, -1 on timeout.
  task automatic wait_done(input int inject_j, output int edges, output int busy_cycles);
    edges       = -1;
    busy_cycles = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == inject_j) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
      end else if (j == inject_j + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        edges = j - 1;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, required all zero",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b, required 0", bus.ovf);
    end
`endif
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int edges;
    int busy_cycles;
    issue(8'h35, 8'h4A, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (edges !== 8) begin
      errors++;
      $display("FAIL basic_latency: done at edge %0d, required 8", edges);
    end
    checks++;
    if (busy_cycles !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: %0d, required 8", busy_cycles);
    end
    checks++;
    if (bus.sum !== 8'h7F || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b, required 7f/0", bus.sum, bus.cout);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_one_cycle: done=%b busy=%b, required 0/0", bus.done, bus.busy);
    end
    checks++;
    if (bus.sum !== 8'h7F) begin
      errors++;
      $display("FAIL basic_sum_held: sum=%h, required 7f", bus.sum);
    end
  endtask

  task automatic test_carry();
    int edges;
    int busy_cycles;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (edges !== 8 || bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_01: edge=%0d sum=%h cout=%b, required 8/00/1", edges, bus.sum, bus.cout);
    end
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (edges !== 8 || bus.sum !== 8'hFF || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_ff_cin: edge=%0d sum=%h cout=%b, required 8/ff/1", edges, bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int edges;
    int busy_cycles;
    int extra;
    issue(8'h10, 8'h20, 1'b0);
    wait_done(3, edges, busy_cycles);
    checks++;
    if (edges !== 8 || bus.sum !== 8'h30 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: edge=%0d sum=%h cout=%b, required 8/30/0", edges, bus.sum, bus.cout);
    end
    extra = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_not_queued: %0d active cycles after done, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    int busy_cycles;
    int pulses;
    issue(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h, required all zero",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: %0d done pulses, required 0", pulses);
    end
    issue(8'h0F, 8'h01, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (edges !== 8 || bus.sum !== 8'h10 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_recover: edge=%0d sum=%h cout=%b, required 8/10/0", edges, bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int times[3];
    int n;
    int bad_sum;
    n       = 0;
    bad_sum = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.cin   = 1'b0;
    for (int j = 0; j < 40 && n < 3; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        times[n] = j;
        n++;
        if (bus.sum !== 8'h03 || bus.cout !== 1'b0) bad_sum++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_pulse_count: %0d pulses, required 3", n);
    end else begin
      checks++;
      if (times[1] - times[0] !== 10 || times[2] - times[1] !== 10) begin
        errors++;
        $display("FAIL b2b_spacing: %0d and %0d cycles, required 10", times[1] - times[0], times[2] - times[1]);
      end
    end
    checks++;
    if (bad_sum !== 0) begin
      errors++;
      $display("FAIL b2b_result: %0d pulses with sum/cout other than 03/0", bad_sum);
    end
    repeat (12) @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int edges;
    int busy_cycles;
    issue(8'h7F, 8'h01, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (bus.sum !== 8'h80 || bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7f_01: sum=%h cout=%b ovf=%b, required 80/0/1", bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    issue(8'h80, 8'h80, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (bus.sum !== 8'h00 || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_80_80: sum=%h cout=%b ovf=%b, required 00/1/1", bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    issue(8'h05, 8'h03, 1'b0);
    wait_done(0, edges, busy_cycles);
    checks++;
    if (bus.sum !== 8'h08 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_05_03: sum=%h ovf=%b, required 08/0", bus.sum, bus.ovf);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
